// File: rtl/rr_mux_n.sv
// rr_mux_n: N-input, WIDTH-bit registered multiplexer with per-channel
// valid/ready handshakes and round-robin or fixed-priority arbitration.
// The output is a single-entry pipeline register (EMPTY/FULL).
//
// Optional feature: define RR_MUX_N_LOCK_EN to add in_last/out_last and
// packet locking (the arbiter stays on a channel until its last beat).
//
// Handshake rule (all channels, both sides): a beat moves on a rising edge
// exactly when valid & ready are both high in the cycle before that edge;
// valid never depends on ready, while in_ready depends combinationally on
// out_ready.
module rr_mux_n #(
  parameter int  WIDTH = 64,
  parameter int  N     = 4,
  parameter real DELAY = 0.05
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
`ifdef RR_MUX_N_LOCK_EN
  input  logic [N-1:0]         in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(N);

  // Elaboration-time parameter sanity; DELAY only models gate delay in
  // gate-level netlists, so the RTL just checks it is meaningful.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_mux_n: N must be in 2..16");
  end
  if (DELAY < 0.0) begin : g_bad_delay
    $error("rr_mux_n: DELAY must be non-negative");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    ptr_inc;
  logic [CW-1:0]    grant;
  logic             grant_valid;
  logic             can_load;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

`ifdef RR_MUX_N_LOCK_EN
  logic             locked;
  logic [CW-1:0]    lock_chan;
`endif

  // Arbitration: fixed picks the lowest valid index, round-robin searches
  // upward from ptr with wrap; an active packet lock overrides both.
  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_valid && in_valid[i]) begin
          grant       = CW'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!grant_valid && in_valid[idx]) begin
          grant       = CW'(idx);
          grant_valid = 1'b1;
        end
      end
    end
`ifdef RR_MUX_N_LOCK_EN
    if (locked) begin
      grant       = lock_chan;
      grant_valid = in_valid[lock_chan];
    end
`endif
  end

  // Handshake qualification and the one-hot ready vector.
  always_comb begin
    can_load = (state == EMPTY) | out_ready;
    accept   = reset_n & can_load & grant_valid;
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // Data select and next pointer (wraps at N-1 for non power-of-two N).
  always_comb begin
    sel_data = in_data[int'(grant)*WIDTH +: WIDTH];
    ptr_inc  = (grant == CW'(N - 1)) ? '0 : grant + CW'(1);
  end

  // Output register FSM next state: load wins over drain (no bubble).
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if (state == FULL && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Output register FSM state.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  assign out_valid = (state == FULL);

  // Output data/channel register; holds its value when drained.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data <= '0;
      out_chan <= '0;
    end else if (accept) begin
      out_data <= sel_data;
      out_chan <= grant;
    end
  end

`ifdef RR_MUX_N_LOCK_EN
  // Round-robin pointer: advances only when a packet completes.
  always_ff @(posedge clk) begin
    if (!reset_n)                             ptr <= '0;
    else if (accept && !mode && in_last[grant]) ptr <= ptr_inc;
  end

  // Packet lock and registered last flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked    <= 1'b0;
      lock_chan <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      locked    <= ~in_last[grant];
      lock_chan <= grant;
      out_last  <= in_last[grant];
    end
  end
`else
  // Round-robin pointer: advances past each granted channel.
  always_ff @(posedge clk) begin
    if (!reset_n)             ptr <= '0;
    else if (accept && !mode) ptr <= ptr_inc;
  end
`endif

endmodule
